// File: rtl/pipe_ksa.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Carry-in rides as an extra prefix bit 0, so the prefix carry at bit i is the carry into operand bit i.
module pipe_ksa #(
    parameter int BITS   = 16,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sum,
    output logic            cout,
    output logic            ovf
);
    localparam int W  = BITS + 1;
    localparam int LV = $clog2(W);

    typedef struct packed {
        logic [W-1:0]    g;
        logic [W-1:0]    p;
        logic [BITS-1:0] x;
        logic            am;
        logic            bm;
    } node_t;

    // Internal boundary i sits after prefix level (i*LV)/STAGES; positions are distinct for legal STAGES.
    function automatic logic is_bnd(input int k);
        for (int i = 1; i < STAGES; i++)
            if ((i * LV) / STAGES == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic node_t pfx(input node_t n, input int d);
        node_t        r;
        logic [W-1:0] lo;
        r   = n;
        lo  = ~({W{1'b1}} << d);
        r.g = n.g | (n.p & (n.g << d));
        r.p = n.p & ((n.p << d) | lo);
        return r;
    endfunction

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vchain;
    logic [BITS-1:0]   bb;
    logic              ci;
    node_t             nd  [0:LV];
    node_t             src [1:LV];
    logic [BITS-1:0]   res_sum;
    logic              res_cout;
    logic              res_ovf;
    logic [BITS-1:0]   sum_q;
    logic              cout_q;
    logic              ovf_q;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign vchain    = {vld_q, in_valid};
    assign out_valid = vld_q[STAGES-1];

    assign bb    = sub ? ~b : b;
    assign ci    = sub ? ~cin : cin;
    assign nd[0] = '{g: {a & bb, ci}, p: {a ^ bb, 1'b0}, x: a ^ bb, am: a[BITS-1], bm: bb[BITS-1]};

    for (genvar k = 0; k < LV; k++) begin : g_lvl
        if (is_bnd(k)) begin : g_reg
            node_t r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   r_q <= '0;
                else if (adv) r_q <= nd[k];
            end
            assign src[k+1] = r_q;
        end else begin : g_wire
            assign src[k+1] = nd[k];
        end
        assign nd[k+1] = pfx(src[k+1], 1 << k);
    end

    assign res_sum  = nd[LV].x ^ nd[LV].g[BITS-1:0];
    assign res_cout = nd[LV].g[BITS];
    assign res_ovf  = (nd[LV].am == nd[LV].bm) && (res_sum[BITS-1] != nd[LV].am);

    // Result fields are zeroed for bubbles so idle outputs read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld_q  <= vchain[STAGES-1:0];
            sum_q  <= vchain[STAGES-1] ? res_sum : '0;
            cout_q <= vchain[STAGES-1] && res_cout;
            ovf_q  <= vchain[STAGES-1] && res_ovf;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_pipe_ksa.sv
// Bench for pipe_ksa: directed cases on an 8-bit/2-stage instance, then random
// handshake traffic on several width/depth instances against an arithmetic model.
module tb_pipe_ksa;
    localparam int NCFG = 5;
    localparam int NTX  = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rnd_go = 1'b0;
    bit   rdone [NCFG];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_bits(input int i);
        case (i)
            0: return 5;
            1: return 8;
            2: return 16;
            default: return 33;
        endcase
    endfunction

    function automatic int cfg_stg(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 5;
            3: return 1;
            default: return 7;
        endcase
    endfunction

    // Reference: plain integer arithmetic; ovf from the signed range of a + bb + ci.
    function automatic logic [65:0] ref_add(input int B, input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
        logic [63:0] mask, av, bv;
        logic        ci;
        logic [64:0] full;
        longint      sa, sb, ss, hi, lo;
        mask = (64'd1 << B) - 64'd1;
        av   = a & mask;
        bv   = sub ? (~b & mask) : (b & mask);
        ci   = sub ? !cin : cin;
        full = {1'b0, av} + {1'b0, bv} + 65'(ci);
        sa   = $signed(av << (64 - B)) >>> (64 - B);
        sb   = $signed(bv << (64 - B)) >>> (64 - B);
        ss   = sa + sb + longint'(ci);
        hi   = (longint'(1) << (B - 1)) - 1;
        lo   = -hi - 1;
        return {(ss > hi) || (ss < lo), full[B], full[63:0] & mask};
    endfunction

    // Directed instance
    logic       d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
    logic [7:0] d_a, d_b, d_sum;

    pipe_ksa #(.BITS(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
    );

    task automatic drv(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        d_in_valid = v; d_a = a; d_b = b; d_cin = c; d_sub = s;
    endtask

    task automatic op_test(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic s, input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk) drv(1'b1, a, b, c, s);
        @(negedge clk) drv(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk) #1;
        chk({tag, ".valid"}, d_out_valid, 1);
        chk({tag, ".sum"}, d_sum, es);
        chk({tag, ".cout"}, d_cout, ec);
        chk({tag, ".ovf"}, d_ovf, eo);
    endtask

    initial begin
        bit all;
        rst_n = 1'b1;
        d_out_ready = 1'b1;
        drv(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", d_out_valid, 0);
        chk("rst.sum", d_sum, 0);
        chk("rst.ready", d_in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op_test("add1", 8'd13, 8'd12, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0);
        op_test("add2", 8'd200, 8'd100, 1'b1, 1'b0, 8'd45, 1'b1, 1'b0);
        op_test("sub1", 8'd5, 8'd7, 1'b0, 1'b1, 8'd254, 1'b0, 1'b0);
        op_test("ovf1", 8'd127, 8'd1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
        op_test("ovf2", 8'h80, 8'd1, 1'b0, 1'b1, 8'd127, 1'b1, 1'b1);

        // Backpressure: three back-to-back operands against a stalled consumer
        @(negedge clk) begin d_out_ready = 1'b0; drv(1'b1, 8'd1, 8'd1, 1'b0, 1'b0); end
        @(negedge clk) drv(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        @(negedge clk) drv(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("bp.ready", d_in_ready, 0);
            chk("bp.valid", d_out_valid, 1);
            chk("bp.hold", d_sum, 2);
        end
        @(negedge clk) d_out_ready = 1'b1;
        #1 chk("bp.out0", d_sum, 2);
        @(negedge clk) drv(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #1 begin chk("bp.out1", d_sum, 4); chk("bp.v1", d_out_valid, 1); end
        @(negedge clk) #1;
        chk("bp.out2", d_sum, 6);
        chk("bp.v2", d_out_valid, 1);
        @(negedge clk) #1;
        chk("bp.drain", d_out_valid, 0);
        chk("bp.zero", d_sum, 0);

        // Reset in the middle of a stalled stream
        @(negedge clk) begin d_out_ready = 1'b0; drv(1'b1, 8'd10, 8'd20, 1'b0, 1'b0); end
        @(negedge clk) drv(1'b1, 8'd30, 8'd40, 1'b0, 1'b0);
        @(negedge clk) #1;
        chk("mid.pre.valid", d_out_valid, 1);
        chk("mid.pre.ready", d_in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.valid", d_out_valid, 0);
        chk("mid.sum", d_sum, 0);
        chk("mid.ready", d_in_ready, 1);
        drv(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk) begin rst_n = 1'b1; d_out_ready = 1'b1; end
        repeat (3) begin
            @(negedge clk) #1;
            chk("mid.flush", d_out_valid, 0);
        end
        op_test("fresh", 8'd9, 8'd9, 1'b1, 1'b0, 8'd19, 1'b0, 1'b0);

        rnd_go = 1'b1;
        all = 1'b0;
        for (int c = 0; c < 60000 && !all; c++) begin
            @(negedge clk);
            all = 1'b1;
            for (int i = 0; i < NCFG; i++) if (!rdone[i]) all = 1'b0;
        end
        chk("rnd.done", all, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Random traffic per configuration; producer holds operands while stalled
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_rnd
        localparam int B = cfg_bits(gi);
        localparam int S = cfg_stg(gi);
        logic [B-1:0] ra, rb, rs;
        logic         rc, rsb, rv, rrdy, rov, rord, rco, rof;

        pipe_ksa #(.BITS(B), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(rrdy), .a(ra), .b(rb),
            .cin(rc), .sub(rsb), .out_valid(rov), .out_ready(rord), .sum(rs),
            .cout(rco), .ovf(rof)
        );

        initial begin
            logic [63:0] q[$];
            logic [63:0] e;
            logic [65:0] r;
            int          sent, rcv;
            bit          hold;
            sent = 0; rcv = 0; hold = 1'b0;
            rv = 1'b0; ra = '0; rb = '0; rc = 1'b0; rsb = 1'b0; rord = 1'b0;
            wait (rnd_go);
            for (int cyc = 0; cyc < 20000 && rcv < NTX; cyc++) begin
                @(negedge clk);
                if (!hold) begin
                    rv  = (sent < NTX) && ($urandom_range(3) != 0);
                    ra  = B'({$urandom(), $urandom()});
                    rb  = B'({$urandom(), $urandom()});
                    rc  = 1'($urandom_range(1));
                    rsb = 1'($urandom_range(1));
                end
                rord = ($urandom_range(3) != 0);
                #1;
                chk($sformatf("rnd%0d.ready", gi), rrdy, rord || !rov);
                if (!rov) chk($sformatf("rnd%0d.idle", gi), 64'({rof, rco, rs}), 0);
                if (rov && rord) begin
                    if (q.size() == 0) chk($sformatf("rnd%0d.extra", gi), q.size(), 1);
                    else begin
                        e = q.pop_front();
                        chk($sformatf("rnd%0d.res", gi), 64'({rof, rco, rs}), e);
                    end
                    rcv++;
                end
                if (rv && rrdy) begin
                    r = ref_add(B, 64'(ra), 64'(rb), rc, rsb);
                    q.push_back((64'(r[65]) << (B + 1)) | (64'(r[64]) << B) | r[63:0]);
                    sent++;
                end
                hold = rv && !rrdy;
            end
            chk($sformatf("rnd%0d.count", gi), rcv, NTX);
            chk($sformatf("rnd%0d.left", gi), q.size(), 0);
            rdone[gi] = 1'b1;
        end
    end
endmodule

// File: doc/pipe_ksa.md
PIPE_KSA -- requirements
Module: pipe_ksa

Interface
REQ-001 Parameter BITS, default 16, operand/result width; legal range 2..64.
REQ-002 Parameter STAGES, default 2, pipeline depth in cycles; legal range 1..clog2(BITS)+1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  BITS  operand A.
REQ-008 b  input  BITS  operand B.
REQ-009 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result on sum/cout/ovf is valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  BITS  result, modulo 2^BITS.
REQ-014 cout  output  1  carry-out of MSB (add), not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic: bb = sub ? ~b : b; ci = sub ? ~cin : cin; {cout,sum} = a + bb + ci, computed with a Kogge-Stone parallel-prefix carry network (generate/propagate, log2 levels).
REQ-017 ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
REQ-018 Pipeline: STAGES register boundaries; the last boundary is the output register; remaining STAGES-1 boundaries lie between prefix levels, evenly spaced; only latency is externally observable.
REQ-019 Advance condition: adv = out_ready || !out_valid; in_ready = adv (combinational from out_ready and out_valid only).
REQ-020 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-021 Latency: with out_ready held 1, an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES cycles of pipeline registers, output visible the cycle after the last register load).
REQ-022 When adv=1 every stage register loads from its predecessor and each stage's valid bit shifts; stage 0 valid loads in_valid.
REQ-023 When adv=0 all stage data and valid bits hold; sum/cout/ovf/out_valid remain stable until transfer out.
REQ-024 Bubbles (valid=0 stages) propagate like data; throughput is one result per cycle when out_ready=1.
REQ-025 Results emerge strictly in acceptance order; no result dropped or duplicated under any out_ready pattern.
REQ-026 Simultaneous transfer in and transfer out in one cycle is permitted and loses nothing.
REQ-027 in_valid while in_ready=0: operand not consumed; producer holds it (no internal skid buffer).
REQ-028 Data registers of stages whose valid bit is 0 may load don't-care values, but sum/cout/ovf are 0 whenever out_valid=0.

Reset
REQ-029 rst_n low asynchronously clears all stage valid bits and data registers: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
REQ-030 Reset mid-operation discards all in-flight operands; first edge after release with in_valid=1 starts a fresh pipeline.
REQ-031 Release of rst_n is synchronous-safe: no transfer occurs on the edge coincident with release.

Verification (BITS=8, STAGES=2 unless stated)
REQ-032 Reset: assert rst_n=0 mid-stream -> out_valid=0, sum=0x00, in_ready=1 immediately, before next clk edge.
REQ-033 Add: a=13, b=12, cin=0, sub=0 -> after 2 cycles sum=25, cout=0, ovf=0; a=200, b=100, cin=1 -> sum=45, cout=1, ovf=0.
REQ-034 Sub/overflow: a=5, b=7, sub=1, cin=0 -> sum=254, cout=0, ovf=0; a=127, b=1, sub=0 -> sum=128, cout=0, ovf=1; a=0x80, b=1, sub=1 -> sum=127, ovf=1.
REQ-035 Backpressure: 3 back-to-back operands (1+1, 2+2, 3+3), out_ready=0 for 4 cycles -> in_ready=0 while stalled, sum=2 held stable; on out_ready=1, 2, 4, 6 delivered on consecutive cycles.
REQ-036 Random: 10k random a/b/cin/sub with random in_valid/out_ready, BITS in {5,8,16,33}, STAGES in {1, max} -> scoreboard matches REQ-016/017 in order, zero loss.
